fetch_queue: RTL and testbench

Instruction fetch stage with a prefetch buffer, sitting directly upstream of decode in the RISC-V core. It owns the fetch PC, issues sequential word reads to a fixed-latency instruction memory, and buffers returned instructions with their PCs in a small FIFO. Decode consumes them through a valid/ready handshake. A redirect from execute (taken branch or jump) flushes all buffered and in-flight fetches and restarts at the target.

---
 rtl/riscv_pkg.sv | 11 +
 rtl/fetch_fifo.sv | 64 ++++++
 rtl/fetch_queue.sv | 92 +++++++++
 tb/tb_fetch_queue.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared constants for the RISC-V core front end.
//   INSTR_W   : instruction word width
//   NOP_INSTR : canonical NOP (addi x0, x0, 0), shown on empty/reset outputs
//   PC_STEP   : byte increment between sequential instruction fetches
package riscv_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h00000013;
  localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   push     : write din at the tail
//   pop      : advance the head (caller guarantees occ != 0)
//   flush    : discard all entries; overrides push/pop
//   din      : write data
//   head     : registered data at the head entry
//   occ      : number of stored entries, 0..DEPTH
// Storage resets to INIT so head shows a defined value out of reset.
module fetch_fifo #(
  parameter int unsigned      WIDTH = 40,
  parameter int unsigned      DEPTH = 4,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             head,
  output logic [$clog2(DEPTH+1)-1:0]   occ
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= INIT;
      end
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch stage with prefetch buffer.
// Owns the fetch PC, issues sequential word reads to a one-cycle-latency
// instruction memory and buffers {instr, pc} pairs for decode.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   imem_req/addr     : read request and word-aligned byte address
//   imem_rdata        : read data, valid one cycle after imem_req
//   redirect/_pc      : flush everything and restart at redirect_pc (low bits ignored)
//   out_valid/ready   : handshake towards decode
//   out_instr/out_pc  : head instruction and its byte address
module fetch_queue
  import riscv_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [31:0]        imem_rdata,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_instr,
  output logic [ADDR_W-1:0]  out_pc
);

  localparam int unsigned OCC_W = $clog2(DEPTH + 1);
  localparam int unsigned ENT_W = INSTR_W + ADDR_W;

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] req_pc;
  logic              inflight;
  logic [OCC_W-1:0]  occ;
  logic [OCC_W:0]    credit;
  logic [ADDR_W-1:0] target;
  logic              push;
  logic              pop;
  logic [ENT_W-1:0]  head;

  assign target = redirect_pc & ~ADDR_W'(3);

  // Slots already committed: buffered entries plus the response still on its
  // way. A same-cycle pop is deliberately not credited.
  always_comb begin
    credit    = {1'b0, occ} + (OCC_W + 1)'(inflight);
    imem_req  = !rst && !redirect && (credit < (OCC_W + 1)'(DEPTH));
    imem_addr = fetch_pc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= '0;
      req_pc   <= '0;
      inflight <= 1'b0;
    end else if (redirect) begin
      fetch_pc <= target;
      inflight <= 1'b0;
    end else begin
      inflight <= imem_req;
      if (imem_req) begin
        req_pc   <= fetch_pc;
        fetch_pc <= fetch_pc + ADDR_W'(PC_STEP);
      end
    end
  end

  assign out_valid = (occ != '0);
  assign push      = inflight && !redirect;
  assign pop       = out_valid && out_ready && !redirect;

  fetch_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH),
    .INIT  ({NOP_INSTR, ADDR_W'(0)})
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .din   ({imem_rdata, req_pc}),
    .head  (head),
    .occ   (occ)
  );

  assign out_instr = head[ENT_W-1:ADDR_W];
  assign out_pc    = head[ADDR_W-1:0];

endmodule

// File: tb/tb_fetch_queue.sv
// Testbench for fetch_queue: directed timing checks plus randomized traffic.
// A stream model (sequential addresses from the last reset/redirect target)
// feeds expectation queues; a monitor checks every request and handshake.
module tb_fetch_queue;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DEPTH  = 4;

  logic              clk;
  logic              rst;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_pc;

  fetch_queue #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_pc      (out_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int handshakes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] word_of(input logic [7:0] a);
    return {~a, a ^ 8'h3C, 8'hA5, a};
  endfunction

  // Instruction memory: one-cycle read latency.
  logic [31:0] pend;
  always @(negedge clk) pend = word_of(imem_addr);
  always @(posedge clk) imem_rdata <= pend;

  // Stream model: after reset or redirect, requests and deliveries are the
  // sequential addresses starting at the restart point.
  logic [ADDR_W-1:0] exp_req_q[$];
  logic [ADDR_W-1:0] exp_out_q[$];
  logic [ADDR_W-1:0] next_req, next_out;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_req_q.delete(); exp_out_q.delete();
      next_req = '0; next_out = '0;
    end else if (redirect) begin
      exp_req_q.delete(); exp_out_q.delete();
      next_req = redirect_pc & 8'hFC; next_out = redirect_pc & 8'hFC;
    end
    while (exp_req_q.size() < 8) begin
      exp_req_q.push_back(next_req); next_req = next_req + 8'd4;
    end
    while (exp_out_q.size() < 8) begin
      exp_out_q.push_back(next_out); next_out = next_out + 8'd4;
    end
  end

  // Monitor: checks every request address and every consumed entry.
  always @(negedge clk) begin
    logic [ADDR_W-1:0] e;
    if (!rst) begin
      if (imem_req) begin
        if (exp_req_q.size() == 0) chk("req_queue_empty", 32'd0, 32'd1);
        else begin
          e = exp_req_q.pop_front();
          chk("imem_addr", {24'd0, imem_addr}, {24'd0, e});
        end
      end
      if (out_valid && out_ready) begin
        handshakes++;
        if (exp_out_q.size() == 0) chk("out_queue_empty", 32'd0, 32'd1);
        else begin
          e = exp_out_q.pop_front();
          chk("out_pc", {24'd0, out_pc}, {24'd0, e});
          chk("out_instr", out_instr, word_of(e));
        end
      end
    end
  end

  task automatic cyc;
    @(posedge clk); #1;
  endtask

  task automatic settle;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    int found;
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b1;

    // Reset then streaming
    repeat (3) cyc();
    settle();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
    chk("rst_out_instr", out_instr, 32'h00000013);
    chk("rst_out_pc", {24'd0, out_pc}, 32'd0);
    cyc(); rst = 1'b0;
    settle();
    chk("c0_req", {31'd0, imem_req}, 32'd1);
    chk("c0_addr", {24'd0, imem_addr}, 32'd0);
    cyc(); settle();
    chk("c1_valid", {31'd0, out_valid}, 32'd0);
    cyc(); settle();
    chk("c2_valid", {31'd0, out_valid}, 32'd1);
    chk("c2_pc", {24'd0, out_pc}, 32'd0);
    repeat (6) begin
      cyc(); settle();
      chk("stream_valid", {31'd0, out_valid}, 32'd1);
      chk("stream_req", {31'd0, imem_req}, 32'd1);
    end

    // Backpressure from reset
    cyc(); rst = 1'b1; out_ready = 1'b0;
    cyc(); rst = 1'b0;
    cnt = 0;
    settle(); if (imem_req) cnt++;
    repeat (7) begin cyc(); settle(); if (imem_req) cnt++; end
    chk("bp_req_count", cnt, 32'd4);
    chk("bp_req_off", {31'd0, imem_req}, 32'd0);
    chk("bp_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_head_pc", {24'd0, out_pc}, 32'd0);
    cyc(); out_ready = 1'b1;
    settle();
    chk("bp_release_no_credit", {31'd0, imem_req}, 32'd0);
    cyc(); settle();
    chk("bp_resume_req", {31'd0, imem_req}, 32'd1);
    chk("bp_resume_addr", {24'd0, imem_addr}, 32'd16);
    repeat (6) cyc();

    // Redirect mid-stream with entries buffered and a fetch in flight
    out_ready = 1'b0;
    repeat (2) cyc();
    redirect = 1'b1; redirect_pc = 8'h2E;
    settle();
    chk("R_req", {31'd0, imem_req}, 32'd0);
    cyc(); redirect = 1'b0; out_ready = 1'b1;
    settle();
    chk("R1_valid", {31'd0, out_valid}, 32'd0);
    chk("R1_addr", {24'd0, imem_addr}, 32'h2C);
    cyc(); settle();
    chk("R2_valid", {31'd0, out_valid}, 32'd0);
    cyc(); settle();
    chk("R3_valid", {31'd0, out_valid}, 32'd1);
    chk("R3_pc", {24'd0, out_pc}, 32'h2C);
    repeat (3) cyc();

    // Wrap-around of the fetch PC
    redirect = 1'b1; redirect_pc = 8'hF8;
    cyc(); redirect = 1'b0;
    for (int i = 0; i < 4; i++) begin
      logic [7:0] a;
      a = 8'hF8 + 8'(4 * i);
      settle();
      chk("wrap_req", {31'd0, imem_req}, 32'd1);
      chk("wrap_addr", {24'd0, imem_addr}, {24'd0, a});
      cyc();
    end
    repeat (3) cyc();

    // Reset mid-operation with occ = 3 and one fetch in flight
    redirect = 1'b1; redirect_pc = 8'h80; out_ready = 1'b0;
    cyc(); redirect = 1'b0;
    repeat (4) cyc();
    settle();
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    chk("pre_rst_pc", {24'd0, out_pc}, 32'h80);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_req", {31'd0, imem_req}, 32'd0);
    chk("async_rst_instr", out_instr, 32'h00000013);
    repeat (2) cyc();
    rst = 1'b0; out_ready = 1'b1;
    settle();
    chk("post_rst_req", {31'd0, imem_req}, 32'd1);
    chk("post_rst_addr", {24'd0, imem_addr}, 32'd0);
    repeat (4) cyc();

    // Pop in the same cycle as a redirect
    redirect = 1'b1; redirect_pc = 8'h41;
    settle();
    chk("pop_redir_valid", {31'd0, out_valid}, 32'd1);
    cyc(); redirect = 1'b0;
    cyc(); cyc(); settle();
    chk("pop_redir_pc", {24'd0, out_pc}, 32'h40);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      cyc();
      out_ready = ($urandom_range(0, 9) < 7);
      redirect = ($urandom_range(0, 15) == 0);
      redirect_pc = 8'($urandom);
      rst = ($urandom_range(0, 199) == 0);
    end
    cyc(); rst = 1'b0; redirect = 1'b0; out_ready = 1'b1;

    // Bounded wait for the stream to reappear after the random phase
    found = 0;
    for (int i = 0; i < 10 && found == 0; i++) begin
      cyc(); settle();
      if (out_valid) found = 1;
    end
    chk("final_valid_within_bound", found, 32'd1);
    chk("handshakes_seen", {31'd0, handshakes > 100}, 32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
